log_compress: RTL and testbench
===============================

# log_compress

Log-compression back end that consumes the normalized `(int_part, data_out)` pair produced by the integer/normalization stage and turns it into a display-ready pixel. It computes log2 of the original sample as an unsigned fixed-point value using a segment LUT with linear interpolation. It then applies a runtime dynamic-range window (offset and gain) and saturates the result to `OUT_WIDTH` bits. The block sits between the normalizer and the scan-conversion/pixel buffer, and uses the same valid/ready handshake on both sides.

## Interface
- `SHIFT_WIDTH`, 4: width of `int_part`; must match the upstream normalizer.
- `FRAC_WIDTH`, 16: fractional mantissa bits.
- `NORM_WIDTH`, `FRAC_WIDTH+1`: mantissa width, implicit leading 1 in the MSB.
- `SEG_BITS`, 4: LUT segment index bits (2^SEG_BITS segments).
- `LOG_FRAC`, 12: fractional bits of the log2 result.
- `GAIN_WIDTH`, 16: gain width, unsigned Q(GAIN_WIDTH-GAIN_SHIFT).GAIN_SHIFT.
- `GAIN_SHIFT`, 12: gain fractional bits.
- `OUT_WIDTH`, 8: pixel width.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  high only in IDLE.
- `int_part`  in  SHIFT_WIDTH  integer part of log2 (MSB index).
- `mant_in`  in  NORM_WIDTH  normalized mantissa; only `[FRAC_WIDTH-1:0]` is used.
- `offset`  in  SHIFT_WIDTH+LOG_FRAC  log-domain floor subtracted before gain.
- `gain`  in  GAIN_WIDTH  dynamic-range gain.
- `out_valid`  out  1  pixel valid.
- `out_ready`  in  1  downstream ready.
- `pixel`  out  OUT_WIDTH  compressed, saturated pixel.
- `log_out`  out  SHIFT_WIDTH+LOG_FRAC  unsigned log2 value, `{int_part, frac_log}`.
- `clip`  out  1  pixel was saturated high.

## Operation
- **FSM states:** IDLE → LOOKUP → INTERP → SCALE → SEND → IDLE.
- **IDLE:**
  - Accept when `in_valid && in_ready`.
  - Capture `int_part`, `mant_in[FRAC_WIDTH-1:0]`, `offset` and `gain` into registers.
  - Changes on `offset`/`gain` after acceptance do not affect the sample in flight.
- **LOOKUP:**
  - `seg = frac[FRAC_WIDTH-1 -: SEG_BITS]`.
  - `rem = frac[FRAC_WIDTH-SEG_BITS-1:0]`.
  - Register `y0 = LUT[seg]` and `y1 = LUT[seg+1]`.
  - LUT has 2^SEG_BITS+1 entries: `LUT[k] = round(log2(1+k/2^SEG_BITS) * 2^LOG_FRAC)`, so `LUT[0]=0` and `LUT[last]=2^LOG_FRAC`.
  - For defaults, `LUT[1]=358` and `LUT[8]=2396`.
- **INTERP:**
  - `frac_log = y0 + (((y1-y0) * rem) >> (FRAC_WIDTH-SEG_BITS))`, truncating.
  - `frac_log < 2^LOG_FRAC` always; no carry into `int_part`.
  - `log_val = {int_part, frac_log}`.
- **SCALE:**
  - `diff = log_val - offset`; if `log_val < offset`, `diff = 0`.
  - `prod = (diff * gain) >> GAIN_SHIFT`, at full product width with no intermediate overflow.
  - If `prod > 2^OUT_WIDTH-1`, then `pixel = 2^OUT_WIDTH-1` and `clip = 1`; else `pixel = prod[OUT_WIDTH-1:0]` and `clip = 0`.
  - Register `log_out = log_val`, and set `out_valid = 1`.
- **SEND:**
  - Hold `pixel`, `log_out`, `clip` and `out_valid` stable while `out_ready = 0`.
  - On an edge with `out_ready = 1`: clear `out_valid`, go to IDLE.
- **Boundary values:** `int_part = 2^SHIFT_WIDTH-1` with `frac` all ones is the maximum `log_val`, with no wrap. `gain = 0` gives `pixel = 0`, `clip = 0`.

## Timing
- **Reset:**
  - `out_valid = 0`, `pixel = 0`, `log_out = 0`, `clip = 0`, state = IDLE, hence `in_ready = 1`.
  - All internal registers are cleared.
  - Reset mid-operation discards the in-flight sample with no output.
- **Latency:** acceptance edge E0; `out_valid` is high after edge E0+3.
- **Throughput:** with `out_ready` held high, `out_valid` lasts 1 cycle and `in_ready` returns the cycle after the E0+4 edge. Peak rate is 1 sample per 5 cycles.
- **No input bypass:** `in_ready` stays low in every non-IDLE state; `in_valid` asserted there is ignored (upstream holds).
- **Ready before valid:** `out_ready` high before `out_valid` does not shorten latency.

## Configuration
- `LOG_COMPRESS_INTERP_EN` defined:
  - LOOKUP/INTERP behave as above.
- `LOG_COMPRESS_INTERP_EN` undefined:
  - No multiplier in INTERP; `frac_log = LUT[seg]` and `rem` is ignored.
  - The `LUT[last]` entry is not required.
  - State sequence and latency are unchanged.

## Test plan
- **Reset:** reset asserted mid-SCALE → next cycle `out_valid=0`, `pixel=0`, `log_out=0`, `clip=0`, `in_ready=1`; no output ever appears for that sample.
- **Integer path:** `int_part=8`, `mant_in=0x10000`, `offset=0`, `gain=16` → `log_out=0x8000`, `pixel=128`, `clip=0`, `out_valid` high after E0+3. Repeat with `int_part=15` → `log_out=0xF000`, `pixel=240`.
- **Segment:** `int_part=0`, `mant_in=0x18000`, `gain=4096` → `log_out=2396`, `pixel=255`, `clip=1`.
- **Interpolation:** `int_part=0`, `mant_in=0x10800` → `log_out=179` with `LOG_COMPRESS_INTERP_EN`, `log_out=0` without.
- **Offset floor:** `int_part=8`, `mant_in=0x10000`, `offset=0x9000`, `gain=4096` → `pixel=0`, `clip=0`. Change `offset` the cycle after acceptance → result unchanged.
- **Backpressure:** hold `out_ready=0` for 10 cycles in SEND → outputs stable, `in_ready=0`, a second `in_valid` is not taken. Raise `out_ready` → `out_valid` drops next edge, second sample accepted the following cycle.

Source files
------------

// File: rtl/log_compress.sv
// log_compress: log-compression back end for the normalizer output.
// Computes log2 of the original sample as {int_part, frac_log} from a
// 17-entry segment LUT, applies a captured offset/gain window and
// saturates to an OUT_WIDTH pixel.
// Optional feature macro: LOG_COMPRESS_INTERP_EN. When it is defined,
// frac_log is linearly interpolated between adjacent LUT entries. When it
// is undefined, frac_log is the LUT entry of the segment and no
// interpolation multiplier is built.
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both high. Once raised, out_valid and the output data stay
// stable until that edge. in_ready is high only while the block is idle.
// The LUT table holds the values for SEG_BITS=4, LOG_FRAC=12.
module log_compress #(
    parameter int SHIFT_WIDTH = 4,
    parameter int FRAC_WIDTH  = 16,
    parameter int NORM_WIDTH  = FRAC_WIDTH + 1,
    parameter int SEG_BITS    = 4,
    parameter int LOG_FRAC    = 12,
    parameter int GAIN_WIDTH  = 16,
    parameter int GAIN_SHIFT  = 12,
    parameter int OUT_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SHIFT_WIDTH-1:0]          int_part,
    input  logic [NORM_WIDTH-1:0]           mant_in,
    input  logic [SHIFT_WIDTH+LOG_FRAC-1:0] offset,
    input  logic [GAIN_WIDTH-1:0]           gain,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_WIDTH-1:0]            pixel,
    output logic [SHIFT_WIDTH+LOG_FRAC-1:0] log_out,
    output logic                            clip,
    output logic [2:0]                      dbg_state
);

    localparam int LOG_W   = SHIFT_WIDTH + LOG_FRAC;
    localparam int REM_W   = FRAC_WIDTH - SEG_BITS;
    localparam int LE_W    = LOG_FRAC + 1;
    localparam int PR_W    = LOG_W + GAIN_WIDTH;
    localparam int PIX_MAX = (1 << OUT_WIDTH) - 1;

    // round(log2(1 + k/16) * 4096), k = 0..16
    localparam int LUT_TAB [0:(1 << SEG_BITS)] = '{
        0, 358, 696, 1016, 1319, 1607, 1882, 2145,
        2396, 2637, 2869, 3092, 3307, 3514, 3715, 3908,
        4096
    };

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_INTERP = 3'd2,
        S_SCALE  = 3'd3,
        S_SEND   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [SHIFT_WIDTH-1:0]  int_q, int_d;
    logic [FRAC_WIDTH-1:0]   frac_q, frac_d;
    logic [LOG_W-1:0]        offset_q, offset_d;
    logic [GAIN_WIDTH-1:0]   gain_q, gain_d;
    logic [LE_W-1:0]         y0_q, y0_d;
    logic [LOG_W-1:0]        log_val_q, log_val_d;
    logic [OUT_WIDTH-1:0]    pixel_q, pixel_d;
    logic [LOG_W-1:0]        log_out_q, log_out_d;
    logic                    clip_q, clip_d;
    logic                    out_valid_q, out_valid_d;

    logic [SEG_BITS-1:0]     seg;
    logic [SEG_BITS:0]       seg_idx;
    logic [LOG_FRAC-1:0]     frac_log;
    logic [LOG_W-1:0]        diff;
    logic [PR_W-1:0]         prod;
    logic                    unused_bits;

    assign seg     = frac_q[FRAC_WIDTH-1 -: SEG_BITS];
    assign seg_idx = {1'b0, seg};

`ifdef LOG_COMPRESS_INTERP_EN
    localparam int DR_W = LE_W + REM_W;

    logic [LE_W-1:0]  y1_q, y1_d;
    logic [REM_W-1:0] rem;
    logic [LE_W-1:0]  dy;
    logic [DR_W-1:0]  step;
    logic [DR_W-1:0]  frac_sum;

    // Linear interpolation inside the segment; y1 >= y0 so dy never wraps
    always_comb begin
        rem      = frac_q[REM_W-1:0];
        dy       = y1_q - y0_q;
        step     = (DR_W'(dy) * DR_W'(rem)) >> REM_W;
        frac_sum = DR_W'(y0_q) + step;
        frac_log = frac_sum[LOG_FRAC-1:0];
    end

    assign unused_bits = ^{mant_in[FRAC_WIDTH], frac_sum[DR_W-1:LOG_FRAC]};
`else
    // Segment value only; the top LUT bit is only set by the final entry
    always_comb begin
        frac_log = y0_q[LOG_FRAC-1:0];
    end

    assign unused_bits = ^{mant_in[FRAC_WIDTH], frac_q[REM_W-1:0], y0_q[LOG_FRAC]};
`endif

    // Offset floor and gain at full product width
    always_comb begin
        diff = (log_val_q >= offset_q) ? (log_val_q - offset_q) : '0;
        prod = (PR_W'(diff) * PR_W'(gain_q)) >> GAIN_SHIFT;
    end

    // Next-state and datapath register updates for the five-step pipeline
    always_comb begin
        state_d     = state_q;
        int_d       = int_q;
        frac_d      = frac_q;
        offset_d    = offset_q;
        gain_d      = gain_q;
        y0_d        = y0_q;
`ifdef LOG_COMPRESS_INTERP_EN
        y1_d        = y1_q;
`endif
        log_val_d   = log_val_q;
        pixel_d     = pixel_q;
        log_out_d   = log_out_q;
        clip_d      = clip_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    int_d    = int_part;
                    frac_d   = mant_in[FRAC_WIDTH-1:0];
                    offset_d = offset;
                    gain_d   = gain;
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                y0_d    = LE_W'(LUT_TAB[seg_idx]);
`ifdef LOG_COMPRESS_INTERP_EN
                y1_d    = LE_W'(LUT_TAB[seg_idx + (SEG_BITS+1)'(1)]);
`endif
                state_d = S_INTERP;
            end
            S_INTERP: begin
                log_val_d = {int_q, frac_log};
                state_d   = S_SCALE;
            end
            S_SCALE: begin
                if (prod > PR_W'(PIX_MAX)) begin
                    pixel_d = OUT_WIDTH'(PIX_MAX);
                    clip_d  = 1'b1;
                end else begin
                    pixel_d = prod[OUT_WIDTH-1:0];
                    clip_d  = 1'b0;
                end
                log_out_d   = log_val_q;
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and data registers; reset drops any sample in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            int_q       <= '0;
            frac_q      <= '0;
            offset_q    <= '0;
            gain_q      <= '0;
            y0_q        <= '0;
`ifdef LOG_COMPRESS_INTERP_EN
            y1_q        <= '0;
`endif
            log_val_q   <= '0;
            pixel_q     <= '0;
            log_out_q   <= '0;
            clip_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            int_q       <= int_d;
            frac_q      <= frac_d;
            offset_q    <= offset_d;
            gain_q      <= gain_d;
            y0_q        <= y0_d;
`ifdef LOG_COMPRESS_INTERP_EN
            y1_q        <= y1_d;
`endif
            log_val_q   <= log_val_d;
            pixel_q     <= pixel_d;
            log_out_q   <= log_out_d;
            clip_q      <= clip_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign pixel     = pixel_q;
    assign log_out   = log_out_q;
    assign clip      = clip_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_log_compress.sv
// tb_log_compress: directed and random samples for log_compress, checked
// against a real-arithmetic log2 reference with offset/gain windowing.
module tb_log_compress;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  int_part;
    logic [16:0] mant_in;
    logic [15:0] offset;
    logic [15:0] gain;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  pixel;
    logic [15:0] log_out;
    logic        clip;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int lut_ref [0:16];
    logic [24:0] exp_q [$];

    log_compress dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .int_part  (int_part),
        .mant_in   (mant_in),
        .offset    (offset),
        .gain      (gain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pixel     (pixel),
        .log_out   (log_out),
        .clip      (clip),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // reference: log2 of 2^ip * (1 + frac/2^16) from the segment table
    function automatic logic [24:0] model(input int ip, input int mant, input int off, input int g);
        int frac, seg, rem, fl, lv, diff;
        longint prod;
        int pix, clp;
        frac = mant % 65536;
        seg  = frac / 4096;
        rem  = frac % 4096;
`ifdef LOG_COMPRESS_INTERP_EN
        fl = lut_ref[seg] + ((lut_ref[seg+1] - lut_ref[seg]) * rem) / 4096;
`else
        fl = lut_ref[seg];
`endif
        lv   = ip * 4096 + fl;
        diff = (lv > off) ? lv - off : 0;
        prod = (longint'(diff) * longint'(g)) / 4096;
        pix  = (prod > 255) ? 255 : int'(prod);
        clp  = (prod > 255) ? 1 : 0;
        return {lv[15:0], pix[7:0], clp[0]};
    endfunction

    // driver: present a sample and wait for the acceptance edge
    task automatic send(input int ip, input int mant, input int off, input int g);
        int n;
        int_part = 4'(ip);
        mant_in  = 17'(mant);
        offset   = 16'(off);
        gain     = 16'(g);
        in_valid = 1'b1;
        exp_q.push_back(model(ip, mant, off, g));
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // called at E0+1ns: checks latency and the result
    task automatic expect_out(input string tag);
        logic [24:0] e;
        e = exp_q.pop_front();
        check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_v0"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_v1"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_v2"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_log"}, {16'd0, log_out}, {16'd0, e[24:9]});
        check({tag, "_pixel"}, {24'd0, pixel}, {24'd0, e[8:1]});
        check({tag, "_clip"}, {31'd0, clip}, {31'd0, e[0]});
    endtask

    // hold out_ready low for hold cycles, then release and see the handoff
    task automatic drain(input string tag, input int hold);
        logic [7:0]  p0;
        logic [15:0] l0;
        p0 = pixel;
        l0 = log_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_v"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_px"}, {24'd0, pixel}, {24'd0, p0});
            check({tag, "_hold_log"}, {16'd0, log_out}, {16'd0, l0});
            check({tag, "_hold_rdy"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int ip, mant, off, g, hold;

        for (int k = 0; k <= 16; k++)
            lut_ref[k] = $rtoi($ln(1.0 + k / 16.0) / $ln(2.0) * 4096.0 + 0.5);

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        int_part = '0; mant_in = '0; offset = '0; gain = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pixel", {24'd0, pixel}, 32'd0);
        check("rst_log", {16'd0, log_out}, 32'd0);
        check("rst_clip", {31'd0, clip}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // integer path, table constants
        check("lut1", lut_ref[1], 358);
        check("lut8", lut_ref[8], 2396);
        send(8, 'h10000, 0, 16);
        expect_out("int8");
        check("int8_log_c", {16'd0, log_out}, 32'h8000);
        check("int8_px_c", {24'd0, pixel}, 32'd128);
        drain("int8", 0);
        send(15, 'h10000, 0, 16);
        expect_out("int15");
        check("int15_log_c", {16'd0, log_out}, 32'hF000);
        check("int15_px_c", {24'd0, pixel}, 32'd240);
        drain("int15", 0);

        // segment boundary with clipping
        send(0, 'h18000, 0, 4096);
        expect_out("seg");
        check("seg_log_c", {16'd0, log_out}, 32'd2396);
        check("seg_px_c", {24'd0, pixel}, 32'd255);
        check("seg_clip_c", {31'd0, clip}, 32'd1);
        drain("seg", 0);

        // interpolation inside segment 0
        send(0, 'h10800, 0, 4096);
        expect_out("interp");
`ifdef LOG_COMPRESS_INTERP_EN
        check("interp_log_c", {16'd0, log_out}, 32'd179);
`else
        check("interp_log_c", {16'd0, log_out}, 32'd0);
`endif
        drain("interp", 0);

        // offset floor; offset and gain change right after acceptance
        send(8, 'h10000, 'h9000, 4096);
        offset = 16'h0000;
        gain   = 16'hFFFF;
        expect_out("floor");
        check("floor_px_c", {24'd0, pixel}, 32'd0);
        check("floor_clip_c", {31'd0, clip}, 32'd0);
        drain("floor", 0);

        // maximum log value, and zero gain
        send(15, 'h1FFFF, 0, 1);
        expect_out("maxlog");
        drain("maxlog", 0);
        send(15, 'h1FFFF, 0, 0);
        expect_out("gain0");
        check("gain0_px_c", {24'd0, pixel}, 32'd0);
        drain("gain0", 0);

        // backpressure: second sample waits until the first is taken
        out_ready = 1'b0;
        send(3, 'h14000, 0, 200);
        expect_out("bp_a");
        int_part = 4'd5; mant_in = 17'h1C000; offset = 16'h1000; gain = 16'd100;
        in_valid = 1'b1;
        exp_q.push_back(model(5, 'h1C000, 'h1000, 100));
        drain("bp_a", 10);
        @(posedge clk); #1;
        check("bp_b_taken", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        expect_out("bp_b");
        drain("bp_b", 0);

        // reset asserted while the sample is in SCALE
        send(8, 'h10000, 0, 16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(exp_q.pop_front());
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_pixel", {24'd0, pixel}, 32'd0);
        check("mid_rst_log", {16'd0, log_out}, 32'd0);
        check("mid_rst_clip", {31'd0, clip}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
        end

        // random samples with random window, late changes and backpressure
        for (int t = 0; t < 40; t++) begin
            ip   = $urandom_range(0, 15);
            mant = 'h10000 + $urandom_range(0, 65535);
            off  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 65535);
            g    = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 65535);
            hold = $urandom_range(0, 3);
            out_ready = (hold == 0);
            send(ip, mant, off, g);
            offset = 16'($urandom);
            gain   = 16'($urandom);
            expect_out("rnd");
            drain("rnd", hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
